// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: default width and direction encodings.
package counter_pkg;

  localparam int   COUNTER_WIDTH = 4;
  localparam logic DIR_UP        = 1'b1;
  localparam logic DIR_DOWN      = 1'b0;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count logic: steps cur by one in the selected direction, modulo 2**WIDTH.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt
);

  // Sums stay WIDTH bits wide, so carry and borrow fall off and the count wraps.
  always_comb begin
    nxt = cur;
    if (dir == DIR_UP) nxt = cur + WIDTH'(1);
    else               nxt = cur - WIDTH'(1);
  end

endmodule

// File: rtl/counter.sv
// Up/down binary counter with asynchronous active-high reset; count is the register output.
module counter
  import counter_pkg::*;
#(
  parameter int               WIDTH     = COUNTER_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             updown,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_next;

  counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .cur (count),
    .dir (updown),
    .nxt (count_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= RESET_VAL;
    else       count <= count_next;
  end

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed phases plus random direction, against an arithmetic model.
`timescale 1ns/100ps
module tb_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         updown;
  logic         reset;
  logic [W-1:0] count;

  int model;
  int errors;
  int checks;

  counter #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk    (clk),
    .updown (updown),
    .reset  (reset),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [W-1:0] exp;
    exp = model[W-1:0];
    checks++;
    assert (count === exp) else begin
      errors++;
      $error("FAIL %s: count=%0d expected=%0d", tag, count, exp);
    end
    $display("%s: count=%0d expected=%0d", tag, count, exp);
  endtask

  // Sample updown at the edge, advance the model, then compare just after the edge.
  task automatic edge_check(input string tag);
    logic dir;
    @(posedge clk);
    dir = updown;
    if (reset) model = 0;
    else if (dir) model = (model + 1) % MOD;
    else model = (model + MOD - 1) % MOD;
    #1;
    check(tag);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model  = 0;
    updown = 1'b1;
    reset  = 1'b1;

    // Phase 1: held in reset with updown toggling.
    #1;
    check("reset_hold_t0");
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      updown = ~updown;
      edge_check("reset_hold");
    end

    // Phase 2: release between edges, count down through the wrap.
    @(negedge clk);
    updown = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 3; i++) edge_check("down_wrap");

    // Phase 3: async clear, then 20 up steps through the wrap.
    @(negedge clk);
    #2 reset = 1'b1;
    model = 0;
    #1;
    check("async_clear");
    #1 reset = 1'b0;
    updown = 1'b1;
    for (int i = 0; i < 20; i++) edge_check("up_wrap");

    // Phase 4: updown toggling every 17 ns, offset so it never lands on an edge.
    @(negedge clk);
    #0.5;
    fork
      begin
        for (int k = 0; k < 30; k++) #17 updown = ~updown;
      end
      begin
        for (int i = 0; i < 50; i++) edge_check("toggle17");
      end
    join

    // Phase 5: step up to 9, then pulse reset between edges.
    @(negedge clk);
    updown = 1'b1;
    for (int i = 0; i < 40 && model != 9; i++) edge_check("to_nine");
    check("at_nine");
    @(negedge clk);
    #1 reset = 1'b1;
    model = 0;
    #1;
    check("mid_reset");
    #1 reset = 1'b0;
    edge_check("resume");
    edge_check("resume");

    // Phase 6: glitch on updown between edges, stable 1 at the edge.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      updown = 1'b1;
      #1 updown = 1'b0;
      #1 updown = 1'b1;
      edge_check("glitch");
    end

    // Random direction each cycle, with occasional async reset pulses.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      updown = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        #1 reset = 1'b1;
        model = 0;
        #1;
        check("rand_reset");
        #1 reset = 1'b0;
      end
      edge_check("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
